// File: rtl/spi_host_link.sv
// SPI mode-0 master for the host side of the controller debug link.
// One fixed-width full-duplex transfer per command, plus a sticky interrupt flag.
module spi_host_link #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned XFER_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [XFER_BITS-1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [XFER_BITS-1:0] rsp_data,
  output logic                 busy,
  output logic                 sck,
  output logic                 cs,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 rw,
  input  logic                 intr,
  output logic                 intr_pending,
  input  logic                 intr_clear
);
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(XFER_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bits_q, bits_d;
  logic [XFER_BITS-1:0] tx_q, tx_d;
  logic [XFER_BITS-1:0] rx_q, rx_d;
  logic [XFER_BITS-1:0] rsp_data_d;
  logic sck_d, cs_d, mosi_d, rw_d, cmd_ready_d, busy_d, rsp_valid_d, intr_pending_d;
  logic miso_meta, miso_sync;
  logic intr_meta, intr_sync, intr_prev;
  logic intr_rise;

  assign intr_rise = intr_sync & ~intr_prev;

  // Next-state and next-output logic; every register has a default hold value.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sck_d       = sck;
    cs_d        = cs;
    mosi_d      = mosi;
    rw_d        = rw;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    // A new edge outranks a simultaneous clear so no interrupt is lost.
    intr_pending_d = intr_rise ? 1'b1 : (intr_clear ? 1'b0 : intr_pending);

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          tx_d    = cmd_data;
          rw_d    = cmd_write;
          mosi_d  = cmd_data[XFER_BITS-1];
          cs_d    = 1'b0;
          cnt_d   = '0;
          bits_d  = BIT_W'(XFER_BITS);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (sck) begin
            // End of high phase: capture miso, fall sck, advance mosi unless last bit.
            sck_d  = 1'b0;
            rx_d   = {rx_q[XFER_BITS-2:0], miso_sync};
            bits_d = bits_q - BIT_W'(1);
            if (bits_q != BIT_W'(1)) begin
              tx_d   = tx_q << 1;
              mosi_d = tx_q[XFER_BITS-2];
            end
          end else if (bits_q == '0) begin
            state_d = HOLD;
          end else begin
            sck_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          cs_d        = 1'b1;
          rw_d        = 1'b0;
          mosi_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State, link pins, status and synchronizers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bits_q       <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      sck          <= 1'b0;
      cs           <= 1'b1;
      mosi         <= 1'b0;
      rw           <= 1'b0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      intr_pending <= 1'b0;
      miso_meta    <= 1'b0;
      miso_sync    <= 1'b0;
      intr_meta    <= 1'b0;
      intr_sync    <= 1'b0;
      intr_prev    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bits_q       <= bits_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      sck          <= sck_d;
      cs           <= cs_d;
      mosi         <= mosi_d;
      rw           <= rw_d;
      cmd_ready    <= cmd_ready_d;
      busy         <= busy_d;
      rsp_valid    <= rsp_valid_d;
      rsp_data     <= rsp_data_d;
      intr_pending <= intr_pending_d;
      miso_meta    <= miso;
      miso_sync    <= miso_meta;
      intr_meta    <= intr;
      intr_sync    <= intr_meta;
      intr_prev    <= intr_sync;
    end
  end

endmodule

// File: tb/tb_spi_host_link.sv
// Directed + randomized bench for spi_host_link: a 32-bit/div-4 instance and an
// 8-bit/div-5 instance, each talking to a simple mode-0 slave model.
module tb_spi_host_link;
  localparam int unsigned A_DIV  = 4;
  localparam int unsigned A_BITS = 32;
  localparam int unsigned B_DIV  = 5;
  localparam int unsigned B_BITS = 8;

  logic clk;
  logic reset;

  logic              a_cmd_valid, a_cmd_ready, a_cmd_write, a_rsp_valid, a_busy;
  logic [A_BITS-1:0] a_cmd_data, a_rsp_data;
  logic              a_sck, a_cs, a_mosi, a_miso, a_rw, a_intr, a_intr_pending, a_intr_clear;

  logic              b_cmd_valid, b_cmd_ready, b_cmd_write, b_rsp_valid, b_busy;
  logic [B_BITS-1:0] b_cmd_data, b_rsp_data;
  logic              b_sck, b_cs, b_mosi, b_miso, b_rw, b_intr, b_intr_pending, b_intr_clear;

  int checks = 0;
  int passed = 0;

  spi_host_link #(.CLK_DIV(A_DIV), .XFER_BITS(A_BITS)) u_dut_a (
    .clk(clk), .reset(reset), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_write(a_cmd_write), .cmd_data(a_cmd_data), .rsp_valid(a_rsp_valid),
    .rsp_data(a_rsp_data), .busy(a_busy), .sck(a_sck), .cs(a_cs), .mosi(a_mosi),
    .miso(a_miso), .rw(a_rw), .intr(a_intr), .intr_pending(a_intr_pending),
    .intr_clear(a_intr_clear)
  );

  spi_host_link #(.CLK_DIV(B_DIV), .XFER_BITS(B_BITS)) u_dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(b_cmd_write), .cmd_data(b_cmd_data), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .busy(b_busy), .sck(b_sck), .cs(b_cs), .mosi(b_mosi),
    .miso(b_miso), .rw(b_rw), .intr(b_intr), .intr_pending(b_intr_pending),
    .intr_clear(b_intr_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave models: present MSB while deselected, move to the next bit on each sck fall.
  logic [A_BITS-1:0] a_slave_word, a_sreg;
  logic              a_sck_d;
  always @(negedge clk) begin
    if (a_cs === 1'b1) begin
      a_sreg <= a_slave_word;
      a_miso <= a_slave_word[A_BITS-1];
    end else if (a_sck_d === 1'b1 && a_sck === 1'b0) begin
      a_sreg <= a_sreg << 1;
      a_miso <= a_sreg[A_BITS-2];
    end
    a_sck_d <= a_sck;
  end

  logic [B_BITS-1:0] b_slave_word, b_sreg;
  logic              b_sck_d;
  always @(negedge clk) begin
    if (b_cs === 1'b1) begin
      b_sreg <= b_slave_word;
      b_miso <= b_slave_word[B_BITS-1];
    end else if (b_sck_d === 1'b1 && b_sck === 1'b0) begin
      b_sreg <= b_sreg << 1;
      b_miso <= b_sreg[B_BITS-2];
    end
    b_sck_d <= b_sck;
  end

  // Cycle at which rsp_valid appears, counting the accept cycle as 0.
  function automatic int exp_rsp(input int bits, input int div);
    return 1 + (2 * bits + 2) * div;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_ready_a();
    int n;
    n = 0;
    while (a_cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", 64'(a_cmd_ready), 64'd1);
  endtask

  // Called in the accept cycle (cmd_valid already driven); returns one cycle after rsp_valid.
  task automatic xfer_a(input logic exp_rw, input logic keep, input logic next_write,
                        input logic [A_BITS-1:0] next_data, output int rsp_cyc,
                        output logic [A_BITS-1:0] rdata, output logic [A_BITS-1:0] mosi_word,
                        output int pulses, output int rw_bad, output int cs_bad,
                        output int hs_bad, output logic [2:0] end_pins);
    int   c;
    logic sck_prev;
    rsp_cyc = -1; rdata = '0; mosi_word = '0; pulses = 0;
    rw_bad = 0; cs_bad = 0; hs_bad = 0; end_pins = 3'b000;
    sck_prev = a_sck;
    tick();
    c = 1;
    if (keep) begin
      a_cmd_data  = next_data;
      a_cmd_write = next_write;
    end else begin
      a_cmd_valid = 1'b0;
    end
    while (rsp_cyc < 0 && c <= 400) begin
      if (a_sck === 1'b1 && sck_prev === 1'b0) begin
        pulses++;
        mosi_word = {mosi_word[A_BITS-2:0], a_mosi};
      end
      sck_prev = a_sck;
      if (a_rsp_valid === 1'b1) begin
        rsp_cyc  = c;
        rdata    = a_rsp_data;
        end_pins = {a_cs, a_rw, a_mosi};
      end else begin
        if (a_rw !== exp_rw) rw_bad++;
        if (a_cs !== 1'b0) cs_bad++;
      end
      if (a_cmd_ready !== 1'b0 || a_busy !== 1'b1) hs_bad++;
      tick();
      c++;
    end
  endtask

  initial begin
    int rc, rc2, pulses, rw_bad, cs_bad, hs_bad, c, gap_hi, acc2, n, seen;
    logic [A_BITS-1:0] rd, mw, d, sw;
    logic [2:0] endp;
    logic wr, sck_prev;

    reset = 1'b1;
    a_cmd_valid = 0; a_cmd_write = 0; a_cmd_data = '0; a_intr = 0; a_intr_clear = 0;
    b_cmd_valid = 0; b_cmd_write = 0; b_cmd_data = '0; b_intr = 0; b_intr_clear = 0;
    a_slave_word = '0; b_slave_word = '0;
    repeat (3) tick();
    chk("reset_held", 64'({a_cs, a_sck, a_mosi, a_rw, a_cmd_ready, a_busy, a_rsp_valid, a_intr_pending}),
        64'b1000_1000);
    reset = 1'b0;
    tick();
    chk("reset_rsp_data", 64'(a_rsp_data), 64'd0);
    chk("reset_b", 64'({b_cs, b_sck, b_cmd_ready, b_busy, b_intr_pending}), 64'b10100);

    // Write transfer
    a_cmd_write = 1'b1; a_cmd_data = 32'hA5C3_0F96; a_cmd_valid = 1'b1;
    xfer_a(1'b1, 1'b0, 1'b0, '0, rc, rd, mw, pulses, rw_bad, cs_bad, hs_bad, endp);
    chk("wr_mosi_word", 64'(mw), 64'h A5C3_0F96);
    chk("wr_sck_pulses", 64'(pulses), 64'd32);
    chk("wr_rsp_cycle", 64'(rc), 64'(exp_rsp(A_BITS, A_DIV)));
    chk("wr_rw_held", 64'(rw_bad), 64'd0);
    chk("wr_cs_held", 64'(cs_bad), 64'd0);
    chk("wr_ready_busy", 64'(hs_bad), 64'd0);
    chk("wr_end_pins", 64'(endp), 64'b100);
    chk("wr_rsp_single", 64'(a_rsp_valid), 64'd0);

    // Read transfer
    wait_ready_a();
    a_slave_word = 32'hDEAD_BEEF; a_cmd_write = 1'b0; a_cmd_data = '0; a_cmd_valid = 1'b1;
    xfer_a(1'b0, 1'b0, 1'b0, '0, rc, rd, mw, pulses, rw_bad, cs_bad, hs_bad, endp);
    chk("rd_data", 64'(rd), 64'h DEAD_BEEF);
    chk("rd_rw_low", 64'(rw_bad), 64'd0);
    chk("rd_rsp_cycle", 64'(rc), 64'(exp_rsp(A_BITS, A_DIV)));
    repeat (5) tick();
    chk("rd_data_held", 64'(a_rsp_data), 64'h DEAD_BEEF);

    // Randomized transfers against the word-level model
    for (int i = 0; i < 4; i++) begin
      wait_ready_a();
      d = $urandom; sw = $urandom; wr = 1'($urandom_range(0, 1));
      a_slave_word = sw; a_cmd_write = wr; a_cmd_data = d; a_cmd_valid = 1'b1;
      xfer_a(wr, 1'b0, 1'b0, '0, rc, rd, mw, pulses, rw_bad, cs_bad, hs_bad, endp);
      chk("rand_rdata", 64'(rd), 64'(sw));
      chk("rand_mosi", 64'(mw), 64'(d));
      chk("rand_rsp_cycle", 64'(rc), 64'(exp_rsp(A_BITS, A_DIV)));
      chk("rand_rw", 64'(rw_bad + cs_bad), 64'd0);
    end

    // Back-to-back with cmd_valid held high
    wait_ready_a();
    a_slave_word = 32'h1234_5678; a_cmd_write = 1'b1; a_cmd_data = 32'h0F0F_1111; a_cmd_valid = 1'b1;
    xfer_a(1'b1, 1'b1, 1'b0, 32'hCAFE_0001, rc, rd, mw, pulses, rw_bad, cs_bad, hs_bad, endp);
    a_slave_word = 32'h8765_4321;
    chk("b2b_first_data", 64'(rd), 64'h1234_5678);
    chk("b2b_ready_low", 64'(hs_bad), 64'd0);
    gap_hi = int'(endp[2]);
    c = rc + 1; acc2 = -1; n = 0;
    while (acc2 < 0 && n < 20) begin
      if (c <= rc + int'(A_DIV) - 1 && a_cs === 1'b1) gap_hi++;
      if (a_cmd_ready === 1'b1) acc2 = c;
      else begin
        tick();
        c++;
      end
      n++;
    end
    chk("b2b_accept", 64'(acc2), 64'(rc + int'(A_DIV)));
    chk("b2b_cs_gap", 64'(gap_hi), 64'(A_DIV));
    xfer_a(1'b0, 1'b0, 1'b0, '0, rc2, rd, mw, pulses, rw_bad, cs_bad, hs_bad, endp);
    chk("b2b_second_data", 64'(rd), 64'h8765_4321);
    chk("b2b_second_mosi", 64'(mw), 64'h CAFE_0001);

    // Interrupt: one-period pulse at an offset from the clock edge
    #2 a_intr = 1'b1;
    #10 a_intr = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_intr_pending === 1'b1) seen = 1;
    end
    chk("intr_set", 64'(seen), 64'd1);
    repeat (3) tick();
    a_intr = 1'b1;
    tick();
    tick();
    a_intr_clear = 1'b1;
    tick();
    a_intr_clear = 1'b0;
    chk("intr_set_beats_clear", 64'(a_intr_pending), 64'd1);
    repeat (2) tick();
    a_intr_clear = 1'b1;
    tick();
    a_intr_clear = 1'b0;
    chk("intr_clear", 64'(a_intr_pending), 64'd0);
    repeat (4) tick();
    chk("intr_level_once", 64'(a_intr_pending), 64'd0);
    a_intr = 1'b0;

    // Reset in the middle of a transfer
    wait_ready_a();
    a_cmd_write = 1'b1; a_cmd_data = $urandom; a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    repeat (99) tick();
    chk("pre_reset_busy", 64'(a_busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_pins", 64'({a_cs, a_sck, a_mosi, a_rw, a_cmd_ready, a_busy}), 64'b100010);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (a_rsp_valid === 1'b1) n++;
      tick();
    end
    chk("rst_mid_no_rsp", 64'(n), 64'd0);
    wait_ready_a();
    d = $urandom; sw = $urandom;
    a_slave_word = sw; a_cmd_write = 1'b0; a_cmd_data = d; a_cmd_valid = 1'b1;
    xfer_a(1'b0, 1'b0, 1'b0, '0, rc, rd, mw, pulses, rw_bad, cs_bad, hs_bad, endp);
    chk("post_rst_rsp_cycle", 64'(rc), 64'(exp_rsp(A_BITS, A_DIV)));
    chk("post_rst_data", 64'(rd), 64'(sw));

    // 8-bit instance, CLK_DIV=5
    chk("b_ready", 64'(b_cmd_ready), 64'd1);
    b_slave_word = 8'hC3; b_cmd_data = 8'h3C; b_cmd_write = 1'b1; b_cmd_valid = 1'b1;
    sck_prev = b_sck;
    tick();
    b_cmd_valid = 1'b0;
    c = 1; rc = -1; mw = '0; pulses = 0; rd = '0; endp = 3'b000;
    while (rc < 0 && c <= 400) begin
      if (b_sck === 1'b1 && sck_prev === 1'b0) begin
        pulses++;
        mw = {mw[A_BITS-2:0], b_mosi};
      end
      sck_prev = b_sck;
      if (b_rsp_valid === 1'b1) begin
        rc = c;
        rd = 32'(b_rsp_data);
        endp = {b_cs, b_rw, b_mosi};
      end
      tick();
      c++;
    end
    chk("b_rsp_cycle", 64'(rc), 64'(exp_rsp(B_BITS, B_DIV)));
    chk("b_rsp_data", 64'(rd), 64'h C3);
    chk("b_mosi_word", 64'(mw), 64'h3C);
    chk("b_sck_pulses", 64'(pulses), 64'd8);
    chk("b_end_pins", 64'(endp), 64'b100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
